// File: rtl/aes_round_sequencer.sv
// Iterative AES round controller: LOAD, INIT (key add), NR-1 full rounds, FINAL, then HOLD until out_ready.
// Every step waits on dp_ack; all outputs come from registers, so nothing combinational reaches an output.
module aes_round_sequencer #(
    parameter int NR    = 14,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             encdec,
    output logic             in_ready,
    output logic             load_state,
    output logic             mode,
    output logic             step_valid,
    input  logic             dp_ack,
    output logic             op_first,
    output logic             op_mid,
    output logic             op_last,
    output logic [IDX_W-1:0] round_idx,
    output logic [IDX_W-1:0] key_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_HOLD
    } state_t;

    typedef struct packed {
        logic in_ready;
        logic load;
        logic step;
        logic first;
        logic mid;
        logic last;
        logic ovld;
        logic busy;
    } flags_t;

    localparam logic [IDX_W-1:0] C_NR       = IDX_W'(NR);
    localparam logic [IDX_W-1:0] C_LAST_MID = IDX_W'(NR - 1);
    localparam logic [IDX_W-1:0] C_ONE      = IDX_W'(1);

    state_t           r_state;
    flags_t           r_flags;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_key;
    logic             r_mode;

    // Output flags for the state being entered; registered alongside the state itself.
    function automatic flags_t dec(input state_t s);
        flags_t f;
        f = '0;
        case (s)
            S_IDLE:  f.in_ready = 1'b1;
            S_LOAD:  begin f.load = 1'b1; f.busy = 1'b1; end
            S_INIT:  begin f.step = 1'b1; f.first = 1'b1; f.busy = 1'b1; end
            S_ROUND: begin f.step = 1'b1; f.mid = 1'b1; f.busy = 1'b1; end
            S_FINAL: begin f.step = 1'b1; f.last = 1'b1; f.busy = 1'b1; end
            S_HOLD:  begin f.ovld = 1'b1; f.busy = 1'b1; end
            default: f.in_ready = 1'b1;
        endcase
        return f;
    endfunction

    // Decrypt walks the key schedule backwards.
    function automatic logic [IDX_W-1:0] key_of(input logic m, input logic [IDX_W-1:0] idx);
        return m ? idx : C_NR - idx;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_flags <= dec(S_IDLE);
            r_idx   <= '0;
            r_key   <= '0;
            r_mode  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_flags <= dec(S_LOAD);
                        r_mode  <= encdec;
                        r_key   <= key_of(encdec, '0);
                    end
                end
                S_LOAD: begin
                    r_state <= S_INIT;
                    r_flags <= dec(S_INIT);
                end
                S_INIT: begin
                    if (dp_ack) begin
                        r_state <= S_ROUND;
                        r_flags <= dec(S_ROUND);
                        r_idx   <= C_ONE;
                        r_key   <= key_of(r_mode, C_ONE);
                    end
                end
                S_ROUND: begin
                    if (dp_ack) begin
                        if (r_idx == C_LAST_MID) begin
                            r_state <= S_FINAL;
                            r_flags <= dec(S_FINAL);
                            r_idx   <= C_NR;
                            r_key   <= key_of(r_mode, C_NR);
                        end else begin
                            r_idx <= r_idx + C_ONE;
                            r_key <= key_of(r_mode, r_idx + C_ONE);
                        end
                    end
                end
                S_FINAL: begin
                    if (dp_ack) begin
                        r_state <= S_HOLD;
                        r_flags <= dec(S_HOLD);
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                        r_flags <= dec(S_IDLE);
                        r_idx   <= '0;
                        r_key   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_flags <= dec(S_IDLE);
                    r_idx   <= '0;
                    r_key   <= '0;
                end
            endcase
        end
    end

    assign in_ready   = r_flags.in_ready;
    assign load_state = r_flags.load;
    assign step_valid = r_flags.step;
    assign op_first   = r_flags.first;
    assign op_mid     = r_flags.mid;
    assign op_last    = r_flags.last;
    assign out_valid  = r_flags.ovld;
    assign busy       = r_flags.busy;
    assign mode       = r_mode;
    assign round_idx  = r_idx;
    assign key_sel    = r_key;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench: per-cycle traces of an NR=14 and an NR=2 sequencer compared against hand-built expectations.
module tb_aes_round_sequencer;

    logic clk;
    logic rst, start, encdec, dp_ack, out_ready;

    logic       a_in_ready, a_load, a_mode, a_sv, a_first, a_mid, a_last, a_ovld, a_busy;
    logic [3:0] a_idx, a_key;
    logic       b_in_ready, b_load, b_mode, b_sv, b_first, b_mid, b_last, b_ovld, b_busy;
    logic [3:0] b_idx, b_key;

    aes_round_sequencer #(.NR(14), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .encdec(encdec),
        .in_ready(a_in_ready), .load_state(a_load), .mode(a_mode),
        .step_valid(a_sv), .dp_ack(dp_ack), .op_first(a_first), .op_mid(a_mid),
        .op_last(a_last), .round_idx(a_idx), .key_sel(a_key),
        .out_valid(a_ovld), .out_ready(out_ready), .busy(a_busy)
    );

    aes_round_sequencer #(.NR(2), .IDX_W(4)) dut2 (
        .clk(clk), .rst(rst), .start(start), .encdec(encdec),
        .in_ready(b_in_ready), .load_state(b_load), .mode(b_mode),
        .step_valid(b_sv), .dp_ack(dp_ack), .op_first(b_first), .op_mid(b_mid),
        .op_last(b_last), .round_idx(b_idx), .key_sel(b_key),
        .out_valid(b_ovld), .out_ready(out_ready), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          run;
        bit          on_b;
        int          cyc;
        logic [16:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [16:0] tr_a[0:63];
    logic [16:0] tr_b[0:63];
    bit          p_start[0:63];
    bit          p_enc[0:63];
    bit          p_ack[0:63];
    bit          p_ordy[0:63];
    int          n_assert = 0;
    int          n_fail   = 0;

    // Packed view: {in_ready, load, busy, step_valid, first, mid, last, out_valid, mode, idx[3:0], key[3:0]}
    function automatic logic [16:0] pk_a();
        return {a_in_ready, a_load, a_busy, a_sv, a_first, a_mid, a_last, a_ovld, a_mode, a_idx, a_key};
    endfunction
    function automatic logic [16:0] pk_b();
        return {b_in_ready, b_load, b_busy, b_sv, b_first, b_mid, b_last, b_ovld, b_mode, b_idx, b_key};
    endfunction

    function automatic logic [16:0] mk(bit ir, bit ld, bit bz, bit sv, bit f, bit m, bit l, bit ov,
                                      bit md, int idx, int key);
        return {ir, ld, bz, sv, f, m, l, ov, md, 4'(idx), 4'(key)};
    endfunction
    function automatic logic [16:0] vi(bit md);
        return mk(1, 0, 0, 0, 0, 0, 0, 0, md, 0, 0);
    endfunction
    function automatic logic [16:0] vl(bit md, int key);
        return mk(0, 1, 1, 0, 0, 0, 0, 0, md, 0, key);
    endfunction
    function automatic logic [16:0] vf(bit md, int key);
        return mk(0, 0, 1, 1, 1, 0, 0, 0, md, 0, key);
    endfunction
    function automatic logic [16:0] vm(bit md, int idx, int key);
        return mk(0, 0, 1, 1, 0, 1, 0, 0, md, idx, key);
    endfunction
    function automatic logic [16:0] vz(bit md, int idx, int key);
        return mk(0, 0, 1, 1, 0, 0, 1, 0, md, idx, key);
    endfunction
    function automatic logic [16:0] vh(bit md, int idx, int key);
        return mk(0, 0, 1, 0, 0, 0, 0, 1, md, idx, key);
    endfunction

    task automatic add(input int run, input bit on_b, input int cyc, input logic [16:0] exp);
        vec_t v;
        v.run = run; v.on_b = on_b; v.cyc = cyc; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input int run, input int cyc,
                         input logic [16:0] act, input logic [16:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s run%0d cyc%0d: got %h expected %h", nm, run, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_pat();
        for (int i = 0; i < 64; i++) begin
            p_start[i] = 1'b0; p_enc[i] = 1'b1; p_ack[i] = 1'b1; p_ordy[i] = 1'b1;
        end
    endtask

    // Input set e is applied across edge e; tr[c] is sampled just after edge c-1.
    task automatic run(input int ncyc);
        tr_a[0] = pk_a();
        tr_b[0] = pk_b();
        for (int e = 0; e < ncyc; e++) begin
            @(negedge clk);
            start = p_start[e]; encdec = p_enc[e]; dp_ack = p_ack[e]; out_ready = p_ordy[e];
            @(posedge clk);
            #1;
            tr_a[e + 1] = pk_a();
            tr_b[e + 1] = pk_b();
        end
    endtask

    task automatic check_run(input int run_id);
        foreach (vecs[i]) begin
            if (vecs[i].run == run_id)
                check(vecs[i].on_b ? "nr2_vec" : "nr14_vec", run_id, vecs[i].cyc,
                      vecs[i].on_b ? tr_b[vecs[i].cyc] : tr_a[vecs[i].cyc], vecs[i].exp);
        end
    endtask

    // Counts of a field over cycles 1..n-1; handshakes pair step_valid with that cycle's dp_ack.
    function automatic int cnt_a(input int bitpos, input int n, input bit with_ack);
        int c = 0;
        for (int k = 1; k < n; k++)
            if (tr_a[k][bitpos] && (!with_ack || p_ack[k])) c++;
        return c;
    endfunction

    initial begin
        // Run 1: encrypt, no stalls; NR=2 instance runs in parallel
        add(1, 0, 0, vi(0));       add(1, 0, 1, vl(1, 0));      add(1, 0, 2, vf(1, 0));
        add(1, 0, 3, vm(1, 1, 1)); add(1, 0, 9, vm(1, 7, 7));   add(1, 0, 15, vm(1, 13, 13));
        add(1, 0, 16, vz(1, 14, 14)); add(1, 0, 17, vh(1, 14, 14)); add(1, 0, 19, vi(1));
        add(1, 1, 1, vl(1, 0));    add(1, 1, 2, vf(1, 0));      add(1, 1, 3, vm(1, 1, 1));
        add(1, 1, 4, vz(1, 2, 2)); add(1, 1, 5, vh(1, 2, 2));   add(1, 1, 6, vi(1));
        // Run 2: decrypt with encdec toggling after acceptance
        add(2, 0, 2, vf(0, 14));   add(2, 0, 3, vm(0, 1, 13));  add(2, 0, 10, vm(0, 8, 6));
        add(2, 0, 16, vz(0, 14, 0)); add(2, 0, 17, vh(0, 14, 0)); add(2, 0, 18, vi(0));
        // Run 3: 3-cycle stalls in INIT, round 7 and FINAL
        add(3, 0, 4, vf(1, 0));    add(3, 0, 5, vf(1, 0));      add(3, 0, 6, vm(1, 1, 1));
        add(3, 0, 12, vm(1, 7, 7)); add(3, 0, 15, vm(1, 7, 7)); add(3, 0, 16, vm(1, 8, 8));
        add(3, 0, 22, vz(1, 14, 14)); add(3, 0, 25, vz(1, 14, 14));
        add(3, 0, 26, vh(1, 14, 14)); add(3, 0, 27, vi(1));
        // Run 4: backpressure, ignored starts while busy, restart as decrypt
        add(4, 0, 6, vm(1, 4, 4)); add(4, 0, 17, vh(1, 14, 14)); add(4, 0, 19, vh(1, 14, 14));
        add(4, 0, 21, vh(1, 14, 14)); add(4, 0, 22, vh(1, 14, 14)); add(4, 0, 23, vi(1));
        add(4, 0, 24, vl(0, 14));  add(4, 0, 25, vf(0, 14));
        add(4, 0, 40, vh(0, 14, 0)); add(4, 0, 41, vi(0));
        // Run 5: dp_ack high in IDLE
        add(5, 0, 1, vi(0));       add(5, 0, 4, vi(0));
        // Run 6: reach round 6 before the mid-block reset
        add(6, 0, 8, vm(1, 6, 6));
        // Run 7: normal block after the reset
        add(7, 0, 0, vi(0));       add(7, 0, 16, vz(1, 14, 14));
        add(7, 0, 17, vh(1, 14, 14)); add(7, 0, 18, vi(1));

        rst = 1'b0; start = 1'b0; encdec = 1'b0; dp_ack = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_nr14", 0, 0, pk_a(), vi(0));
        check("reset_nr2", 0, 0, pk_b(), vi(0));
        @(negedge clk);
        rst = 1'b1;

        clear_pat();
        p_start[0] = 1'b1;
        run(20);
        check_run(1);
        for (int c = 2; c <= 16; c++) check("enc_key_seq", 1, c, 17'(tr_a[c][3:0]), 17'(c - 2));
        check_int("enc_load_pulses", cnt_a(15, 20, 0), 1);
        check_int("enc_op_first", cnt_a(12, 20, 0), 1);
        check_int("enc_op_mid", cnt_a(11, 20, 0), 13);
        check_int("enc_op_last", cnt_a(10, 20, 0), 1);
        check_int("enc_handshakes", cnt_a(13, 20, 1), 15);
        check_int("enc_out_valid", cnt_a(9, 20, 0), 1);

        clear_pat();
        p_start[0] = 1'b1;
        for (int e = 0; e < 64; e++) p_enc[e] = (e % 2 == 1);
        run(20);
        check_run(2);
        for (int c = 2; c <= 16; c++) check("dec_key_seq", 2, c, 17'(tr_a[c][3:0]), 17'(16 - c));

        clear_pat();
        p_start[0] = 1'b1;
        for (int e = 2; e <= 4; e++) p_ack[e] = 1'b0;
        for (int e = 12; e <= 14; e++) p_ack[e] = 1'b0;
        for (int e = 22; e <= 24; e++) p_ack[e] = 1'b0;
        run(28);
        check_run(3);
        check_int("stall_handshakes", cnt_a(13, 28, 1), 15);
        check_int("stall_out_valid", cnt_a(9, 28, 0), 1);

        clear_pat();
        p_start[0] = 1'b1;
        p_start[5] = 1'b1;  p_enc[5] = 1'b0;
        p_start[17] = 1'b1; p_start[20] = 1'b1;
        for (int e = 17; e <= 21; e++) p_ordy[e] = 1'b0;
        p_start[23] = 1'b1; p_enc[23] = 1'b0;
        run(42);
        check_run(4);
        check_int("bp_load_pulses", cnt_a(15, 42, 0), 2);

        clear_pat();
        run(5);
        check_run(5);

        clear_pat();
        p_start[0] = 1'b1;
        run(8);
        check_run(6);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("reset_async", 6, 8, pk_a(), vi(0));
        @(posedge clk);
        #1;
        check("reset_held", 6, 9, pk_a(), vi(0));
        @(negedge clk);
        rst = 1'b1;

        clear_pat();
        p_start[0] = 1'b1;
        run(19);
        check_run(7);
        check_int("post_reset_out_valid", cnt_a(9, 19, 0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
